// File: rtl/circbuf_pkg.sv
// Shared definitions for the multi-port circular buffer.
//   ptr_op_e  : operation applied to a buffer pointer each cycle
//   is_pow2   : parameter legality helper (DEPTH must be a power of two)
//   max2      : larger of two parameter values
//   ptr_add   : pointer add with wrap at a given pointer width
package circbuf_pkg;

  typedef enum logic [1:0] {
    PTR_HOLD    = 2'd0,
    PTR_ADVANCE = 2'd1,
    PTR_LOAD    = 2'd2
  } ptr_op_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Wraps modulo 2^w, so the top (wrap) bit toggles on every pass of the array.
  function automatic logic [31:0] ptr_add(input logic [31:0] p, input logic [31:0] n,
                                          input int unsigned w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (p + n) & mask;
  endfunction

endpackage

// File: rtl/circbuf_ptr.sv
// One circular-buffer pointer (index bits plus a wrap bit).
//   clock, reset : rising-edge clock, async active-high reset (pointer -> 0)
//   op_i         : hold, advance by adv_i, or load from load_i
//   adv_i        : advance amount (already clamped by the owner)
//   load_i       : value loaded on PTR_LOAD
//   ptr_o        : registered pointer
module circbuf_ptr
  import circbuf_pkg::*;
#(
  parameter int unsigned PTRW = 5,
  parameter int unsigned NW   = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  ptr_op_e         op_i,
  input  logic [NW-1:0]   adv_i,
  input  logic [PTRW-1:0] load_i,
  output logic [PTRW-1:0] ptr_o
);

  logic [PTRW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    unique case (op_i)
      PTR_ADVANCE: ptr_d = PTRW'(ptr_add(32'(ptr_q), 32'(adv_i), PTRW));
      PTR_LOAD:    ptr_d = load_i;
      default:     ptr_d = ptr_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/circbuf_mp.sv
// Multi-port circular buffer between fetch and decode/issue.
// Accepts 0..INS_COUNT elements per cycle, presents the oldest EXT_COUNT
// entries oldest-first, retires 0..EXT_COUNT per cycle, uses all DEPTH entries.
//   clock, reset   : rising-edge clock, async active-high reset
//   flush          : discard all contents (highest priority)
//   ins_enable     : insert request; ins_count elements from new_elements[0..]
//   ins_ready      : at least INS_COUNT free entries
//   ins_dropped    : one-cycle pulse after a rejected (non-flush) request
//   ext_consumed   : number of window entries retired (clamped to used_count)
//   out_elements   : oldest-first window, ext_valid marks live slots
//   used_count, free_count, empty, full : registered occupancy status
module circbuf_mp
  import circbuf_pkg::*;
#(
  parameter type         T         = logic [31:0],
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned INS_COUNT = 2,
  parameter int unsigned EXT_COUNT = 2,
  localparam int unsigned PTRW     = $clog2(DEPTH) + 1,
  localparam int unsigned ICW      = $clog2(INS_COUNT + 1),
  localparam int unsigned ECW      = $clog2(EXT_COUNT + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 ins_enable,
  input  logic [ICW-1:0]       ins_count,
  input  T                     new_elements [INS_COUNT],
  output logic                 ins_ready,
  output logic                 ins_dropped,
  input  logic [ECW-1:0]       ext_consumed,
  output T                     out_elements [EXT_COUNT],
  output logic [EXT_COUNT-1:0] ext_valid,
  output logic [PTRW-1:0]      used_count,
  output logic [PTRW-1:0]      free_count,
  output logic                 empty,
  output logic                 full
);

  localparam int unsigned IW = PTRW - 1;

  if (!is_pow2(DEPTH)) begin : g_depth_not_pow2
    $error("circbuf_mp: DEPTH must be a power of 2");
  end
  if (DEPTH < 2 * max2(INS_COUNT, EXT_COUNT)) begin : g_depth_too_small
    $error("circbuf_mp: DEPTH must be >= 2*max(INS_COUNT,EXT_COUNT)");
  end

  logic [PTRW-1:0]  ins_ptr, ext_ptr;
  logic [PTRW-1:0]  used, free;
  logic             accept;
  logic [ECW-1:0]   ext_n;
  ptr_op_e          ins_op, ext_op;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             ins_dropped_q;
  logic [IW-1:0]    rd_idx [EXT_COUNT];
  T                 mem [DEPTH];

  // Modulo 2^PTRW difference; the wrap bit distinguishes full from empty.
  assign used = ins_ptr - ext_ptr;
  assign free = PTRW'(DEPTH) - used;

  assign accept = ins_enable & ~flush & (PTRW'(ins_count) <= free);
  assign ext_n  = (PTRW'(ext_consumed) > used) ? ECW'(used) : ext_consumed;

  // Flush collapses the buffer by pulling the insert pointer back to the extract pointer.
  always_comb begin
    ins_op = PTR_HOLD;
    ext_op = PTR_HOLD;
    if (flush) begin
      ins_op = PTR_LOAD;
    end else begin
      if (accept) ins_op = PTR_ADVANCE;
      ext_op = PTR_ADVANCE;
    end
  end

  circbuf_ptr #(.PTRW(PTRW), .NW(ICW)) u_ins_ptr (
    .clock  (clock),
    .reset  (reset),
    .op_i   (ins_op),
    .adv_i  (ins_count),
    .load_i (ext_ptr),
    .ptr_o  (ins_ptr)
  );

  circbuf_ptr #(.PTRW(PTRW), .NW(ECW)) u_ext_ptr (
    .clock  (clock),
    .reset  (reset),
    .op_i   (ext_op),
    .adv_i  (ext_n),
    .load_i ('0),
    .ptr_o  (ext_ptr)
  );

  // Storage is not reset; entries only become visible through the valid/used state.
  always_ff @(posedge clock) begin
    if (accept && !reset) begin
      for (int unsigned i = 0; i < INS_COUNT; i++) begin
        if (ICW'(i) < ins_count) mem[IW'(ins_ptr + PTRW'(i))] <= new_elements[i];
      end
    end
  end

  // Cleared and set ranges never overlap: retired entries are live, inserted ones are free.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int unsigned e = 0; e < EXT_COUNT; e++) begin
        if (ECW'(e) < ext_n) valid_d[IW'(ext_ptr + PTRW'(e))] = 1'b0;
      end
      for (int unsigned i = 0; i < INS_COUNT; i++) begin
        if (accept && (ICW'(i) < ins_count)) valid_d[IW'(ins_ptr + PTRW'(i))] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q       <= '0;
      ins_dropped_q <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      ins_dropped_q <= ins_enable & ~flush & ~accept;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < EXT_COUNT; i++) begin
      rd_idx[i]       = IW'(ext_ptr + PTRW'(i));
      out_elements[i] = mem[rd_idx[i]];
      ext_valid[i]    = (PTRW'(i) < used) & valid_q[rd_idx[i]];
    end
  end

  assign used_count  = used;
  assign free_count  = free;
  assign empty       = (used == '0);
  assign full        = (used == PTRW'(DEPTH));
  assign ins_ready   = (free >= PTRW'(INS_COUNT));
  assign ins_dropped = ins_dropped_q;

endmodule

// File: tb/tb_circbuf_mp.sv
// Self-checking bench for circbuf_mp (DEPTH=16, INS_COUNT=2, EXT_COUNT=2).
// A queue model holds the expected buffer contents: accepted inserts are
// pushed when driven, retired entries popped, and every output is compared
// one time unit after each rising edge.
module tb_circbuf_mp;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        ins_enable;
  logic [1:0]  ins_count;
  logic [31:0] new_elements [2];
  logic        ins_ready;
  logic        ins_dropped;
  logic [1:0]  ext_consumed;
  logic [31:0] out_elements [2];
  logic [1:0]  ext_valid;
  logic [4:0]  used_count;
  logic [4:0]  free_count;
  logic        empty;
  logic        full;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] mdl [$];
  bit          exp_drop = 1'b0;

  circbuf_mp #(.DEPTH(16), .INS_COUNT(2), .EXT_COUNT(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .ins_enable   (ins_enable),
    .ins_count    (ins_count),
    .new_elements (new_elements),
    .ins_ready    (ins_ready),
    .ins_dropped  (ins_dropped),
    .ext_consumed (ext_consumed),
    .out_elements (out_elements),
    .ext_valid    (ext_valid),
    .used_count   (used_count),
    .free_count   (free_count),
    .empty        (empty),
    .full         (full)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned sz;
    sz = mdl.size();
    chk({tag, ".used"},  32'(used_count),  sz);
    chk({tag, ".free"},  32'(free_count),  16 - sz);
    chk({tag, ".empty"}, 32'(empty),       32'(sz == 0));
    chk({tag, ".full"},  32'(full),        32'(sz == 16));
    chk({tag, ".ready"}, 32'(ins_ready),   32'((16 - sz) >= 2));
    chk({tag, ".drop"},  32'(ins_dropped), 32'(exp_drop));
    chk({tag, ".evld"},  32'(ext_valid),   {30'd0, sz > 1, sz > 0});
    for (int i = 0; i < 2; i++) begin
      if (i < sz) chk({tag, ".out"}, out_elements[i], mdl[i]);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; ins_enable = 1'b0; ins_count = 2'd0; ext_consumed = 2'd0;
    new_elements[0] = '0; new_elements[1] = '0;
  endtask

  // Drives one cycle of stimulus, updates the model and checks after the edge.
  task automatic step(input string tag, input bit fl, input bit en, input int unsigned cnt,
                      input logic [31:0] e0, input logic [31:0] e1, input int unsigned cons);
    int unsigned sz, n;
    bit acc;
    sz  = mdl.size();
    acc = en && !fl && (cnt <= 16 - sz);
    n   = (cons < sz) ? cons : sz;
    flush = fl; ins_enable = en; ins_count = 2'(cnt);
    new_elements[0] = e0; new_elements[1] = e1; ext_consumed = 2'(cons);
    @(posedge clock);
    #1;
    if (fl) begin
      mdl.delete();
      exp_drop = 1'b0;
    end else begin
      repeat (n) void'(mdl.pop_front());
      if (acc && cnt > 0) mdl.push_back(e0);
      if (acc && cnt > 1) mdl.push_back(e1);
      exp_drop = en && !acc;
    end
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    mdl.delete();
    exp_drop = 1'b0;
    @(posedge clock);
    #1;
    check_all("rst");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    check_all("reset");
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Basic insert, one-cycle visibility.
    step("ins2", 0, 1, 2, 32'hA, 32'hB, 0);

    // Fill to full, then a rejected insert pulses ins_dropped for one cycle.
    do_reset();
    for (int i = 0; i < 8; i++) step("fill", 0, 1, 2, 32'h100 + 2 * i, 32'h101 + 2 * i, 0);
    step("reject", 0, 1, 1, 32'hDEAD, 32'hBEEF, 0);
    step("dropclr", 0, 0, 0, 0, 0, 0);

    // Drain to one entry, then an over-consume is clamped.
    for (int i = 0; i < 7; i++) step("drain", 0, 0, 0, 0, 0, 2);
    step("drain1", 0, 0, 0, 0, 0, 1);
    step("clamp", 0, 0, 0, 0, 0, 2);
    step("postclamp", 0, 1, 1, 32'h55, 0, 0);

    // Insert window straddling index 15 -> 0 with a concurrent extract.
    do_reset();
    for (int i = 0; i < 7; i++) step("pre", 0, 1, 2, 32'h200 + i, 32'h300 + i, 0);
    step("pre1", 0, 1, 1, 32'h2FF, 0, 0);
    for (int i = 0; i < 7; i++) step("predrain", 0, 0, 0, 0, 0, 2);
    step("wrapXY", 0, 1, 2, 32'hAAAA_0001, 32'hAAAA_0002, 1);
    step("wrapext", 0, 0, 0, 0, 0, 1);

    // Flush beats concurrent insert and extract.
    do_reset();
    for (int i = 0; i < 5; i++) step("pref", 0, 1, 2, 32'h400 + i, 32'h500 + i, 0);
    step("flush", 1, 1, 2, 32'hF0, 32'hF1, 2);
    step("postflush", 0, 1, 2, 32'h600, 32'h601, 0);

    // Random mix, alternating fill-biased and drain-biased phases.
    for (int c = 0; c < 10000; c++) begin
      bit fill_phase;
      fill_phase = ((c / 400) % 2) == 0;
      step("rand", $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2), $urandom, $urandom,
           fill_phase ? $urandom_range(0, 1) : $urandom_range(0, 2));
    end

    // Reset mid-burst: outputs return to reset values without waiting for an edge.
    step("burst", 0, 1, 2, 32'h700, 32'h701, 0);
    step("burst", 0, 1, 2, 32'h702, 32'h703, 1);
    #3;
    reset = 1'b1;
    mdl.delete();
    exp_drop = 1'b0;
    #1;
    check_all("midrst");
    @(posedge clock);
    #1;
    check_all("rsthold");
    reset = 1'b0;
    step("afterrst", 0, 1, 2, 32'h800, 32'h801, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
